// File: rtl/usb_ep_echo_client.sv
// Loopback client for one USB endpoint: pops a received OUT packet, buffers it,
// and returns it (XOR-masked) as the next IN packet through the fill interface.
`timescale 1ns/1ps

module usb_ep_echo_client #(
  parameter int unsigned BUF_DEPTH = 64,
  parameter logic [7:0]  XOR_MASK  = 8'h00,
  parameter int unsigned CNT_WID   = 16
) (
  input  logic               clk12_i,
  input  logic               rst_i,
  input  logic               enable_i,
  input  logic               EP_IN_dataAvailable_i,
  input  logic [7:0]         EP_IN_data_i,
  output logic               EP_IN_popData_o,
  output logic               EP_IN_popTransDone_o,
  output logic               EP_IN_popTransSuccess_o,
  input  logic               EP_OUT_full_i,
  output logic               EP_OUT_dataValid_o,
  output logic [7:0]         EP_OUT_data_o,
  output logic               EP_OUT_fillTransDone_o,
  output logic               EP_OUT_fillTransSuccess_o,
  output logic               busy_o,
  output logic               pktDropped_o,
  output logic [CNT_WID-1:0] pktCount_o
);

  localparam int unsigned LW = $clog2(BUF_DEPTH + 1);
  localparam int unsigned AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READ      = 3'd1,
    COMMIT_RD = 3'd2,
    WRITE     = 3'd3,
    COMMIT_WR = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [LW-1:0]      len_q, len_d;
  logic [LW-1:0]      rd_idx_q, rd_idx_d;
  logic               ovf_q, ovf_d;
  logic [CNT_WID-1:0] cnt_q, cnt_d;
  logic [7:0]         pkt_buf_q [BUF_DEPTH];
  logic [7:0]         pkt_buf_d [BUF_DEPTH];

  // Next-state and datapath updates
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    rd_idx_d  = rd_idx_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    pkt_buf_d = pkt_buf_q;
    case (state_q)
      IDLE: begin
        if (enable_i && EP_IN_dataAvailable_i) begin
          len_d    = '0;
          rd_idx_d = '0;
          ovf_d    = 1'b0;
          state_d  = READ;
        end
      end
      READ: begin
        if (EP_IN_dataAvailable_i) begin
          // Bytes beyond the buffer are still popped so the transaction drains.
          if (len_q < LW'(BUF_DEPTH)) begin
            pkt_buf_d[AW'(len_q)] = EP_IN_data_i;
            len_d                 = len_q + LW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end else begin
          state_d = COMMIT_RD;
        end
      end
      COMMIT_RD: begin
        state_d = ovf_q ? IDLE : WRITE;
      end
      WRITE: begin
        if (!EP_OUT_full_i) begin
          rd_idx_d = rd_idx_q + LW'(1);
          if (rd_idx_q == len_q - LW'(1)) begin
            state_d = COMMIT_WR;
          end
        end
      end
      COMMIT_WR: begin
        cnt_d   = cnt_q + CNT_WID'(1);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk12_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      len_q    <= '0;
      rd_idx_q <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      rd_idx_q <= rd_idx_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

  // Packet storage carries no reset; contents are only read after being written.
  always_ff @(posedge clk12_i) begin
    pkt_buf_q <= pkt_buf_d;
  end

  assign EP_IN_popData_o           = (state_q == READ) && EP_IN_dataAvailable_i;
  assign EP_IN_popTransDone_o      = (state_q == COMMIT_RD);
  assign EP_IN_popTransSuccess_o   = (state_q == COMMIT_RD);
  assign pktDropped_o              = (state_q == COMMIT_RD) && ovf_q;
  assign EP_OUT_dataValid_o        = (state_q == WRITE) && !EP_OUT_full_i;
  assign EP_OUT_data_o             = (state_q == WRITE) ? (pkt_buf_q[AW'(rd_idx_q)] ^ XOR_MASK) : 8'h00;
  assign EP_OUT_fillTransDone_o    = (state_q == COMMIT_WR);
  assign EP_OUT_fillTransSuccess_o = (state_q == COMMIT_WR);
  assign busy_o                    = (state_q != IDLE);
  assign pktCount_o                = cnt_q;

endmodule

// File: tb/tb_usb_ep_echo_client.sv
// Directed bench for usb_ep_echo_client: instance a (64 B, mask 00, 16-bit count)
// and instance b (8 B, mask FF, 2-bit count), each driven by a small host model.
`timescale 1ns/1ps

`define CHK(T, O, E) \
  begin \
    ncmp++; \
    assert ((O) === (E)) else begin \
      nerr++; \
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", T, (O), (E)); \
    end \
  end

module tb_usb_ep_echo_client;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       en_a, av_a, full_a;
  logic [7:0] din_a;
  logic       pop_a, pdone_a, psucc_a, dv_a, fdone_a, fsucc_a, busy_a, drop_a;
  logic [7:0] dout_a;
  logic [15:0] cnt_a;

  logic       en_b, av_b, full_b;
  logic [7:0] din_b;
  logic       pop_b, pdone_b, psucc_b, dv_b, fdone_b, fsucc_b, busy_b, drop_b;
  logic [7:0] dout_b;
  logic [1:0] cnt_b;

  usb_ep_echo_client #(.BUF_DEPTH(64), .XOR_MASK(8'h00), .CNT_WID(16)) u_a (
    .clk12_i(clk), .rst_i(rst), .enable_i(en_a),
    .EP_IN_dataAvailable_i(av_a), .EP_IN_data_i(din_a),
    .EP_IN_popData_o(pop_a), .EP_IN_popTransDone_o(pdone_a),
    .EP_IN_popTransSuccess_o(psucc_a), .EP_OUT_full_i(full_a),
    .EP_OUT_dataValid_o(dv_a), .EP_OUT_data_o(dout_a),
    .EP_OUT_fillTransDone_o(fdone_a), .EP_OUT_fillTransSuccess_o(fsucc_a),
    .busy_o(busy_a), .pktDropped_o(drop_a), .pktCount_o(cnt_a)
  );

  usb_ep_echo_client #(.BUF_DEPTH(8), .XOR_MASK(8'hFF), .CNT_WID(2)) u_b (
    .clk12_i(clk), .rst_i(rst), .enable_i(en_b),
    .EP_IN_dataAvailable_i(av_b), .EP_IN_data_i(din_b),
    .EP_IN_popData_o(pop_b), .EP_IN_popTransDone_o(pdone_b),
    .EP_IN_popTransSuccess_o(psucc_b), .EP_OUT_full_i(full_b),
    .EP_OUT_dataValid_o(dv_b), .EP_OUT_data_o(dout_b),
    .EP_OUT_fillTransDone_o(fdone_b), .EP_OUT_fillTransSuccess_o(fsucc_b),
    .busy_o(busy_b), .pktDropped_o(drop_b), .pktCount_o(cnt_b)
  );

  int ncmp = 0;
  int nerr = 0;

  logic [7:0] pkt   [16];
  logic [7:0] exp_b [16];
  logic [7:0] outq  [$];

  int r_pops, r_rdc, r_drops, r_fc, r_bad, r_ovl, r_fcyc, r_fullv, r_fullcyc, r_done;
  logic       s_pop, s_pdone, s_psucc, s_dv, s_fdone, s_fsucc, s_busy, s_drop;
  logic [7:0] s_dout;
  logic [15:0] s_cnt;

  task automatic drive(input int k, input logic av, input logic [7:0] d, input logic fu);
    if (k == 0) begin
      av_a = av; din_a = d; full_a = fu;
    end else begin
      av_b = av; din_b = d; full_b = fu;
    end
  endtask

  task automatic sample(input int k);
    if (k == 0) begin
      s_pop = pop_a; s_pdone = pdone_a; s_psucc = psucc_a; s_dv = dv_a; s_dout = dout_a;
      s_fdone = fdone_a; s_fsucc = fsucc_a; s_busy = busy_a; s_drop = drop_a; s_cnt = cnt_a;
    end else begin
      s_pop = pop_b; s_pdone = pdone_b; s_psucc = psucc_b; s_dv = dv_b; s_dout = dout_b;
      s_fdone = fdone_b; s_fsucc = fsucc_b; s_busy = busy_b; s_drop = drop_b; s_cnt = 16'(cnt_b);
    end
  endtask

  // Host model: presents pkt[0..n-1] on EP_IN, optionally holds EP_OUT full
  // for stall_len cycles once stall_at bytes have been written, and logs events.
  task automatic run_pkt(input int k, input int n, input int stall_at, input int stall_len);
    int idx = 0;
    int cyc = 0;
    int stalled = 0;
    int extra = 0;
    logic fu;
    r_pops = 0; r_rdc = 0; r_drops = 0; r_fc = 0; r_bad = 0; r_ovl = 0;
    r_fcyc = -1; r_fullv = 0; r_fullcyc = 0; r_done = 0;
    outq.delete();
    while (cyc < 300 && extra < 4) begin
      @(negedge clk);
      fu = (outq.size() >= stall_at) && (stalled < stall_len);
      drive(k, idx < n, (idx < n) ? pkt[idx] : 8'h00, fu);
      #1;
      sample(k);
      if (fu) begin
        stalled++;
        r_fullcyc++;
        if (s_dv) r_fullv++;
      end
      if (s_pop) begin idx++; r_pops++; end
      if (s_pdone) begin r_rdc++; if (!s_psucc) r_bad++; end
      if (s_fdone) begin r_fc++; if (!s_fsucc) r_bad++; r_fcyc = cyc; end
      if (s_drop) r_drops++;
      if (s_dv) outq.push_back(s_dout);
      if (s_pop && (s_dv || s_fdone)) r_ovl++;
      if (r_done != 0) extra++;
      if (s_fdone || s_drop) r_done = 1;
      cyc++;
    end
    drive(k, 1'b0, 8'h00, 1'b0);
    `CHK("packet_completes", r_done, 1)
  endtask

  task automatic check_echo(input int n);
    `CHK("echo_len", outq.size(), n)
    for (int i = 0; i < n && i < outq.size(); i++) begin
      `CHK("echo_byte", outq[i], exp_b[i])
    end
  endtask

  initial begin
    int idx;
    int cnt_strobes;
    int pops;
    en_a = 1'b0; av_a = 1'b0; full_a = 1'b0; din_a = 8'h00;
    en_b = 1'b0; av_b = 1'b0; full_b = 1'b0; din_b = 8'h00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    `CHK("rst_busy_a", busy_a, 1'b0)
    `CHK("rst_dout_a", dout_a, 8'h00)
    `CHK("rst_cnt_a", cnt_a, 16'd0)
    `CHK("rst_pdone_a", pdone_a, 1'b0)
    `CHK("rst_fdone_a", fdone_a, 1'b0)
    `CHK("rst_drop_a", drop_a, 1'b0)
    `CHK("rst_busy_b", busy_b, 1'b0)
    `CHK("rst_cnt_b", cnt_b, 2'd0)
    rst = 1'b0;

    // 4-byte packet, no mask
    pkt[0] = 8'h01; pkt[1] = 8'h02; pkt[2] = 8'h03; pkt[3] = 8'h04;
    exp_b[0] = 8'h01; exp_b[1] = 8'h02; exp_b[2] = 8'h03; exp_b[3] = 8'h04;
    en_a = 1'b1;
    run_pkt(0, 4, 0, 0);
    `CHK("t1_pops", r_pops, 4)
    `CHK("t1_rd_commits", r_rdc, 1)
    `CHK("t1_fill_commits", r_fc, 1)
    `CHK("t1_done_wo_success", r_bad, 0)
    `CHK("t1_pop_fill_overlap", r_ovl, 0)
    `CHK("t1_drops", r_drops, 0)
    `CHK("t1_fill_cycle", r_fcyc, 11)
    check_echo(4);
    `CHK("t1_count", cnt_a, 16'd1)

    // 1-byte packet through mask FF; IDLE-accept cycle 0 .. fill commit cycle 5
    pkt[0] = 8'hA5;
    exp_b[0] = 8'h5A;
    en_b = 1'b1;
    run_pkt(1, 1, 0, 0);
    `CHK("t2_fill_cycle", r_fcyc, 5)
    check_echo(1);
    `CHK("t2_count", cnt_b, 2'd1)

    // 10-byte packet into an 8-byte buffer is dropped
    for (int i = 0; i < 10; i++) pkt[i] = 8'(8'h10 + i);
    run_pkt(1, 10, 0, 0);
    `CHK("t3_pops", r_pops, 10)
    `CHK("t3_rd_commits", r_rdc, 1)
    `CHK("t3_drops", r_drops, 1)
    `CHK("t3_fill_commits", r_fc, 0)
    `CHK("t3_out_bytes", outq.size(), 0)
    `CHK("t3_count", cnt_b, 2'd1)

    // Following packet echoes normally
    pkt[0] = 8'h11; pkt[1] = 8'h22; pkt[2] = 8'h33;
    exp_b[0] = 8'hEE; exp_b[1] = 8'hDD; exp_b[2] = 8'hCC;
    run_pkt(1, 3, 0, 0);
    check_echo(3);
    `CHK("t4_fill_commits", r_fc, 1)
    `CHK("t4_count", cnt_b, 2'd2)

    // 8-byte packet with EP_OUT full for 5 cycles after 3 bytes written
    for (int i = 0; i < 8; i++) begin
      pkt[i]   = 8'(8'h80 + i);
      exp_b[i] = 8'(8'h80 + i);
    end
    run_pkt(0, 8, 3, 5);
    `CHK("t5_pops", r_pops, 8)
    `CHK("t5_full_cycles", r_fullcyc, 5)
    `CHK("t5_valid_while_full", r_fullv, 0)
    check_echo(8);
    `CHK("t5_count", cnt_a, 16'd2)

    // Reset during READ after 2 of 6 bytes
    for (int i = 0; i < 6; i++) pkt[i] = 8'(8'hC0 + i);
    idx = 0;
    cnt_strobes = 0;
    for (int c = 0; c < 20 && idx < 2; c++) begin
      @(negedge clk);
      drive(0, 1'b1, pkt[idx], 1'b0);
      #1;
      if (pop_a) idx++;
      if (pdone_a || fdone_a) cnt_strobes++;
    end
    `CHK("t6_popped_two", idx, 2)
    @(negedge clk);
    drive(0, 1'b1, pkt[2], 1'b0);
    rst = 1'b1;
    #1;
    `CHK("t6_busy_before_reset", busy_a, 1'b1)
    @(negedge clk);
    drive(0, 1'b0, 8'h00, 1'b0);
    #1;
    `CHK("t6_busy", busy_a, 1'b0)
    `CHK("t6_pop", pop_a, 1'b0)
    `CHK("t6_dout", dout_a, 8'h00)
    `CHK("t6_dv", dv_a, 1'b0)
    `CHK("t6_drop", drop_a, 1'b0)
    `CHK("t6_cnt_a", cnt_a, 16'd0)
    `CHK("t6_cnt_b", cnt_b, 2'd0)
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      if (pdone_a || fdone_a) cnt_strobes++;
    end
    `CHK("t6_no_done_strobes", cnt_strobes, 0)

    // Counter wrap: 5 packets on a 2-bit counter
    pkt[0] = 8'h3C;
    exp_b[0] = 8'hC3;
    for (int p = 0; p < 5; p++) run_pkt(1, 1, 0, 0);
    check_echo(1);
    `CHK("t7_count_wrap", cnt_b, 2'd1)

    // Disabled: data available but nothing is popped
    en_b = 1'b0;
    pops = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      drive(1, 1'b1, 8'h77, 1'b0);
      #1;
      if (pop_b || busy_b) pops++;
    end
    drive(1, 1'b0, 8'h00, 1'b0);
    `CHK("t8_disabled_activity", pops, 0)

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
